// File: rtl/linebuffer_nrow.sv
// -----------------------------------------------------------------------------
// linebuffer_nrow
//
// N-row line buffer for streaming raster images. Each accepted pixel is
// presented one cycle later together with the pixels in the same column of
// the previous ROWS-1 lines, forming a vertical column for downstream window
// or convolution stages. The line length is chosen at run time and is latched
// at column 0 of every line. A sof pulse restarts the frame fill count.
//
// Parameters
//   ROWS        rows in the output column (2..8)
//   DATA_WIDTH  bits per pixel
//   ADDR_WIDTH  column address width
//   MAX_LENGTH  maximum line length in pixels (<= 2**ADDR_WIDTH)
//
// Ports
//   clk        single clock, rising edge
//   rst        asynchronous reset, active-high
//   data_in    input pixel
//   in_valid   data_in and sof are valid this cycle
//   sof        first pixel of a new frame (qualified by in_valid)
//   line_len   requested line length; 0 or > MAX_LENGTH means MAX_LENGTH
//   data_out   column output; slice k is the pixel from k lines ago
//   out_valid  data_out is a full column
//   out_sol    data_out is column 0 of a line
//   out_eol    data_out is the last column of a line
//   line_cnt   lines stored since sof/reset, saturating at ROWS-1
// -----------------------------------------------------------------------------
module linebuffer_nrow #(
   parameter int ROWS       = 3,
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 7,
   parameter int MAX_LENGTH = 100
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [DATA_WIDTH-1:0]      data_in,
   input  logic                       in_valid,
   input  logic                       sof,
   input  logic [ADDR_WIDTH:0]        line_len,
   output logic [ROWS*DATA_WIDTH-1:0] data_out,
   output logic                       out_valid,
   output logic                       out_sol,
   output logic                       out_eol,
   output logic [2:0]                 line_cnt
);

   localparam logic [ADDR_WIDTH:0] MAX_LEN = (ADDR_WIDTH+1)'(MAX_LENGTH);
   localparam logic [2:0]          FULL    = 3'(ROWS-1);

   logic [ADDR_WIDTH-1:0] col;
   logic [ADDR_WIDTH:0]   len_q;
   logic [2:0]            fill;

   logic [ADDR_WIDTH-1:0] c;         // effective column of this pixel
   logic [ADDR_WIDTH:0]   len_in;    // clamped requested length
   logic [ADDR_WIDTH:0]   len_eff;   // length governing this line
   logic [2:0]            fill_eff;  // fill after any sof clear
   logic [2:0]            fill_inc;  // saturating fill increment
   logic                  last;      // this pixel closes the line

   logic [ROWS-1:0][DATA_WIDTH-1:0] tap;

   always_comb begin
      c        = sof ? '0 : col;
      len_in   = (line_len == '0 || line_len > MAX_LEN) ? MAX_LEN : line_len;
      // The length is only sampled at column 0; mid-line changes are ignored.
      len_eff  = (c == '0) ? len_in : len_q;
      fill_eff = sof ? 3'd0 : fill;
      fill_inc = (fill_eff == FULL) ? FULL : fill_eff + 3'd1;
      last     = ({1'b0, c} == len_eff - (ADDR_WIDTH+1)'(1));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col       <= '0;
         len_q     <= MAX_LEN;
         fill      <= 3'd0;
         data_out  <= '0;
         out_valid <= 1'b0;
         out_sol   <= 1'b0;
         out_eol   <= 1'b0;
      end else begin
         // Flags are evaluated with the post-sof fill, before the increment.
         out_valid <= in_valid && (fill_eff == FULL);
         out_sol   <= in_valid && (c == '0);
         out_eol   <= in_valid && last;
         if (in_valid) begin
            data_out <= tap;
            len_q    <= len_eff;
            if (last) begin
               col  <= '0;
               fill <= fill_inc;
            end else begin
               col  <= c + ADDR_WIDTH'(1);
               fill <= fill_eff;
            end
         end
      end
   end

   assign line_cnt = fill;
   assign tap[0]   = data_in;

   // Each line memory forms one stage of a per-column shift register:
   // memory k reads the pixel k lines back and receives the value memory k-1
   // held before this write, so all stages shift in the same cycle.
   generate
      for (genvar gi = 1; gi < ROWS; gi++) begin : g_row
         logic [DATA_WIDTH-1:0] mem [0:MAX_LENGTH-1];

         assign tap[gi] = mem[c];

         always_ff @(posedge clk) begin
            if (in_valid) begin
               mem[c] <= tap[gi-1];
            end
         end
      end
   endgenerate

endmodule

// File: tb/tb_linebuffer_nrow.sv
// -----------------------------------------------------------------------------
// tb_linebuffer_nrow
//
// Scoreboard bench for linebuffer_nrow. The driver updates a reference model
// per accepted pixel and queues the expected output beat; a negedge monitor
// pops and compares whenever the DUT raises out_valid, out_sol or out_eol.
// The model keeps, per column, the history of pixels written at that column;
// slice k of a column is simply the k-th most recent pixel at that column.
// -----------------------------------------------------------------------------
module tb_linebuffer_nrow;

   localparam int ROWS = 3;
   localparam int DW   = 16;
   localparam int AW   = 7;
   localparam int MAXL = 100;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic [DW-1:0]      data_in = '0;
   logic               in_valid = 1'b0;
   logic               sof = 1'b0;
   logic [AW:0]        line_len = '0;
   logic [ROWS*DW-1:0] data_out;
   logic               out_valid;
   logic               out_sol;
   logic               out_eol;
   logic [2:0]         line_cnt;

   always #5 clk = ~clk;

   linebuffer_nrow #(
      .ROWS(ROWS), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_LENGTH(MAXL)
   ) dut (
      .clk(clk), .rst(rst), .data_in(data_in), .in_valid(in_valid),
      .sof(sof), .line_len(line_len), .data_out(data_out),
      .out_valid(out_valid), .out_sol(out_sol), .out_eol(out_eol),
      .line_cnt(line_cnt)
   );

   typedef struct {
      logic [ROWS*DW-1:0] data;
      int                 known;   // number of low slices with defined data
      logic               valid;
      logic               sol;
      logic               eol;
      logic [2:0]         cnt;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;

   int vectors     = 0;
   int miscompares = 0;

   // reference model state
   int                 m_col  = 0;
   int                 m_len  = MAXL;
   int                 m_fill = 0;
   int                 hist [0:MAXL-1][$];
   logic [ROWS*DW-1:0] m_last = '0;
   bit                 m_last_known = 1'b1;
   bit                 prev_idle = 1'b0;

   function automatic void check(input string name, input logic [63:0] act,
                                 input logic [63:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
      end
   endfunction

   task automatic check_zero_outputs(input string tag);
      check({tag, "_data"},  64'(data_out),  64'd0);
      check({tag, "_valid"}, 64'(out_valid), 64'd0);
      check({tag, "_sol"},   64'(out_sol),   64'd0);
      check({tag, "_eol"},   64'(out_eol),   64'd0);
      check({tag, "_cnt"},   64'(line_cnt),  64'd0);
   endtask

   task automatic model_reset();
      m_col        = 0;
      m_len        = MAXL;
      m_fill       = 0;
      m_last       = '0;
      m_last_known = 1'b1;
   endtask

   // After an idle edge the outputs must be low and data_out unchanged.
   task automatic hold_check();
      if (prev_idle && m_last_known) begin
         check("idle_hold", 64'(data_out), 64'(m_last));
         check("idle_flags", {61'd0, out_valid, out_sol, out_eol}, 64'd0);
      end
      prev_idle = 1'b0;
   endtask

   task automatic send(input logic [DW-1:0] d, input bit s, input int ll);
      int   c, len, f;
      exp_t e;
      @(posedge clk);
      #1;
      hold_check();
      data_in  = d;
      sof      = s;
      line_len = ll[AW:0];
      in_valid = 1'b1;

      c = s ? 0 : m_col;
      if (c == 0) m_len = (ll == 0 || ll > MAXL) ? MAXL : ll;
      len = m_len;
      f   = s ? 0 : m_fill;

      e.data        = '0;
      e.data[DW-1:0] = d;
      e.known       = 1;
      for (int k = 1; k < ROWS; k++) begin
         if (hist[c].size() >= k && e.known == k) begin
            e.data[k*DW +: DW] = DW'(hist[c][k-1]);
            e.known++;
         end
      end
      hist[c].push_front(int'(d));
      if (hist[c].size() > ROWS-1) void'(hist[c].pop_back());

      e.valid = (f == ROWS-1);
      e.sol   = (c == 0);
      e.eol   = (c == len-1);
      if (e.eol) begin
         m_col  = 0;
         m_fill = (f + 1 > ROWS-1) ? ROWS-1 : f + 1;
      end else begin
         m_col  = c + 1;
         m_fill = f;
      end
      e.cnt        = 3'(m_fill);
      m_last       = e.data;
      m_last_known = (e.known == ROWS);
      if (e.valid || e.sol || e.eol) sb.push_back(e);
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
      hold_check();
      in_valid  = 1'b0;
      sof       = 1'b0;
      data_in   = DW'($urandom);
      prev_idle = 1'b1;
   endtask

   // Reset asserted asynchronously between clock edges with a pixel pending.
   task automatic midline_reset();
      @(posedge clk);
      #1;
      hold_check();
      in_valid = 1'b1;
      sof      = 1'b0;
      data_in  = DW'($urandom);
      #6;
      rst = 1'b1;
      #1;
      check_zero_outputs("async_rst");
      in_valid = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      rst       = 1'b0;
      prev_idle = 1'b1;
   endtask

   // monitor
   always @(negedge clk) begin
      if (!rst && (out_valid || out_sol || out_eol)) begin
         if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_beat: got valid=%0b sol=%0b eol=%0b, expected no beat at %0t",
                     out_valid, out_sol, out_eol, $time);
         end else begin
            logic [ROWS*DW-1:0] mask;
            mon_e = sb.pop_front();
            check("out_valid", 64'(out_valid), 64'(mon_e.valid));
            check("out_sol",   64'(out_sol),   64'(mon_e.sol));
            check("out_eol",   64'(out_eol),   64'(mon_e.eol));
            check("line_cnt",  64'(line_cnt),  64'(mon_e.cnt));
            if (mon_e.valid) begin
               mask = '0;
               for (int k = 0; k < ROWS; k++)
                  if (k < mon_e.known) mask[k*DW +: DW] = '1;
               check("data_out", 64'(data_out & mask), 64'(mon_e.data & mask));
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int len, n, ll;
      repeat (2) @(posedge clk);
      #1;
      check_zero_outputs("reset");
      rst = 1'b0;

      // line_len=0 behaves as MAX_LENGTH; fills every column's history
      for (int i = 0; i < 3*MAXL; i++) send(DW'($urandom), i == 0, 0);
      // oversize line_len also clamps to MAX_LENGTH
      for (int i = 0; i < MAXL; i++) send(DW'($urandom), 1'b0, MAXL+5);

      // L=4, pixels 0..15 contiguous
      for (int i = 0; i < 16; i++) send(DW'(i), i == 0, 4);
      // same stream with idle cycles in between
      for (int i = 0; i < 16; i++) begin
         send(DW'(i), i == 0, 4);
         idle();
      end

      // line_len change mid-line takes effect on the next line
      for (int i = 0; i < 22; i++) send(DW'(100 + i), i == 0, (i < 2) ? 4 : 6);

      // sof at pixel 6 of a running L=4 frame
      for (int i = 0; i < 6; i++)  send(DW'(200 + i), i == 0, 4);
      for (int i = 0; i < 12; i++) send(DW'(300 + i), i == 0, 4);

      // async reset mid-line, then resume without sof
      for (int i = 0; i < 7; i++)  send(DW'(400 + i), i == 0, 5);
      midline_reset();
      for (int i = 0; i < 15; i++) send(DW'(500 + i), 1'b0, 5);

      // L=1: every pixel is a full line
      for (int i = 0; i < 6; i++) send(DW'(600 + i), i == 0, 1);

      // randomized frames with gaps and occasional line_len perturbation
      for (int fr = 0; fr < 25; fr++) begin
         len = $urandom_range(1, 12);
         n   = len * $urandom_range(3, 6) + $urandom_range(0, len-1);
         for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) idle();
            ll = len;
            if ($urandom_range(0, 15) == 0) ll = $urandom_range(1, 15);
            send(DW'($urandom), i == 0, ll);
         end
      end

      repeat (4) idle();
      check("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/linebuffer_nrow.md
# linebuffer_nrow

Parametrised N-row line buffer for streaming raster images. It accepts one pixel per valid cycle and presents a vertical column of ROWS pixels: the current pixel plus the same column from the previous ROWS-1 lines. The line length is set at run time, and start-of-frame flushing is supported. It sits between the pixel source and the ROWSxK window or convolution stages, replacing hand-chained fixed-length line buffers.

## Interface
- ROWS, 3, rows in the output column (2..8); ROWS-1 line memories are instantiated
- DATA_WIDTH, 16, bits per pixel
- ADDR_WIDTH, 7, column address width
- MAX_LENGTH, 100, maximum line length in pixels, at most 2**ADDR_WIDTH
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous reset, active-high
- data_in  in  DATA_WIDTH  input pixel
- in_valid  in  1  data_in and sof are valid this cycle
- sof  in  1  the pixel is the first of a new frame; qualified by in_valid
- line_len  in  ADDR_WIDTH+1  active line length in pixels
- data_out  out  ROWS*DATA_WIDTH  column output; slice k holds the pixel from k lines ago; slice 0 (LSBs) is the current pixel
- out_valid  out  1  data_out is a full column
- out_sol  out  1  data_out is column 0 of a line
- out_eol  out  1  data_out is the last column of a line
- line_cnt  out  3  lines completely stored since sof or reset, saturating at ROWS-1

## Operation
- State: col (ADDR_WIDTH bits), len_q (ADDR_WIDTH+1 bits), fill (line_cnt), and ROWS-1 memories mem[1..ROWS-1] of MAX_LENGTH x DATA_WIDTH each.
- Asynchronous reads; synchronous writes occur only on in_valid.
- Effective column c: 0 if sof=1, otherwise col.
- Effective length L: line_len sampled when c==0 and in_valid. A value of 0 or greater than MAX_LENGTH is clamped to MAX_LENGTH. L is held in len_q for the rest of the line; a change mid-line is ignored.
- On in_valid:
  - tap[0]=data_in and tap[k]=mem[k][c] for k≥1.
  - Write mem[1][c]<=data_in and mem[k][c]<=mem[k-1][c] (the old value) for k=2..ROWS-1.
  - Register data_out<=tap.
  - If c==L-1: col<=0 and fill<=min(fill+1, ROWS-1). Otherwise col<=c+1.
- sof with in_valid forces fill to 0 for this pixel, so the line completes as line 1. Memory contents are not cleared.
- out_valid<=in_valid && (fill==ROWS-1), evaluated after any sof clear and before the increment. The first valid column is therefore line ROWS-1, column 0 of each frame.
- out_sol<=in_valid && c==0.
- out_eol<=in_valid && c==L-1.
- When in_valid is low, no state changes. out_valid, out_sol and out_eol go low; data_out holds its value.
- L=1 is legal: every pixel is both sol and eol, and fill increments on every pixel.

## Timing
- Reset (async assert): col=0, len_q=MAX_LENGTH, fill=0, data_out=0, out_valid=0, out_sol=0, out_eol=0, line_cnt=0. Memory is not reset.
- Latency is 1 cycle from in_valid and data_in to data_out and out_valid.
- Throughput is one pixel per clk. No backpressure: the downstream block must accept every out_valid beat.
- Gaps in in_valid (any length, mid-line included) are transparent.
- If reset asserts mid-line, it takes effect immediately. The next pixel is treated as column 0 of line 0, regardless of sof.
- sof arriving mid-line abandons the partial line. Columns at or beyond the abandoned position hold stale data, but they are only read after fill has rebuilt.
- line_cnt changes on the clock edge after the eol pixel.

## Test plan
- ROWS=3, L=4, stream pixels 0..15 contiguously with sof on pixel 0 -> out_valid first high on the cycle after pixel 8. That column is data_out={0,4,8}: slice2=0, slice1=4, slice0=8. out_sol=1 on that beat; out_eol=1 on the beat for pixel 11.
- Same stream with in_valid toggling 1/0 each cycle -> identical sequence of valid columns; outputs are low on idle cycles and data_out holds.
- Change line_len from 4 to 6 mid-line -> the current line still wraps at 4. The next line uses 6, and out_eol appears at column 5.
- Assert sof at pixel 6 of a running L=4 frame -> line_cnt drops to 0. out_valid stays low until 2 full lines plus 1 pixel later.
- Assert rst asynchronously mid-line with in_valid high -> all outputs are 0 within the same cycle. The next pixel is accepted as column 0, and out_valid resumes only after 2 new lines.
- line_len=0 and line_len=MAX_LENGTH+5 -> both behave as MAX_LENGTH: out_eol at column 99, then wrap to 0. line_len=1 -> out_sol=out_eol=1 on every beat, and out_valid from the third pixel.
